paddle_motion_ctrl: RTL



---
 rtl/paddle_pkg.sv | 49 ++++
 rtl/paddle_step_calc.sv | 81 ++++++++
 rtl/paddle_motion_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/paddle_pkg.sv
// Shared constants, sequencer state encoding and joystick zone classification
// for the paddle motion controller.
package paddle_pkg;

  localparam int            DEF_NUM_CH       = 2;
  localparam int            DEF_Y_MIN        = 10;
  localparam int            DEF_Y_MAX        = 470;
  localparam int            DEF_PADDLE_H     = 50;
  localparam int            DEF_Y_RESET      = 40;
  localparam logic [9:0]    DEF_DOWN_FAST    = 10'h2d0;
  localparam logic [9:0]    DEF_DOWN_SLOW    = 10'h220;
  localparam logic [9:0]    DEF_UP_SLOW      = 10'h180;
  localparam logic [9:0]    DEF_UP_FAST      = 10'h0a0;
  localparam int            DEF_SLOW_STEP    = 1;
  localparam int            DEF_FAST_STEP    = 3;
  localparam int            DEF_BOOST_STEP   = 6;
  localparam int            DEF_ACCEL_FRAMES = 30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } seq_state_t;

  // Zones are named after the joystick boundary they lie beyond; a high raw
  // reading (DOWN_* zones) moves the paddle up, i.e. towards smaller y.
  typedef enum logic [2:0] {
    ZONE_UP_FAST,
    ZONE_UP_SLOW,
    ZONE_HOLD,
    ZONE_DOWN_SLOW,
    ZONE_DOWN_FAST
  } zone_t;

  function automatic zone_t classify_zone(
    input logic [9:0] joy,
    input logic [9:0] down_fast,
    input logic [9:0] down_slow,
    input logic [9:0] up_slow,
    input logic [9:0] up_fast
  );
    if (joy > down_fast)      return ZONE_DOWN_FAST;
    else if (joy > down_slow) return ZONE_DOWN_SLOW;
    else if (joy > up_slow)   return ZONE_HOLD;
    else if (joy > up_fast)   return ZONE_UP_SLOW;
    else                      return ZONE_UP_FAST;
  endfunction

endpackage

// File: rtl/paddle_step_calc.sv
// Combinational next-position calculation for one paddle channel; the top
// shares a single instance across channels during its sweep.
module paddle_step_calc
  import paddle_pkg::*;
#(
  parameter int         Y_MIN        = DEF_Y_MIN,
  parameter int         Y_LIM        = DEF_Y_MAX - DEF_PADDLE_H,
  parameter logic [9:0] DOWN_FAST    = DEF_DOWN_FAST,
  parameter logic [9:0] DOWN_SLOW    = DEF_DOWN_SLOW,
  parameter logic [9:0] UP_SLOW      = DEF_UP_SLOW,
  parameter logic [9:0] UP_FAST      = DEF_UP_FAST,
  parameter int         SLOW_STEP    = DEF_SLOW_STEP,
  parameter int         FAST_STEP    = DEF_FAST_STEP,
  parameter int         BOOST_STEP   = DEF_BOOST_STEP,
  parameter int         ACCEL_FRAMES = DEF_ACCEL_FRAMES,
  parameter int         CNT_W        = 5
) (
  input  logic [9:0]       y_cur,
  input  logic [9:0]       joy,
  input  logic             valid,
  input  logic             pos_mode,
  input  logic [CNT_W-1:0] hold_cnt,
  input  zone_t            prev_zone,
  output logic [9:0]       y_next,
  output logic [CNT_W-1:0] hold_cnt_next,
  output zone_t            zone_next
);

  localparam logic signed [10:0] Y_LO    = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI    = 11'(Y_LIM);
  localparam logic signed [10:0] SLOW_S  = 11'(SLOW_STEP);
  localparam logic signed [10:0] FAST_S  = 11'(FAST_STEP);
  localparam logic signed [10:0] BOOST_S = 11'(BOOST_STEP);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(ACCEL_FRAMES);

  zone_t             zone;
  logic              fast;
  logic [9:0]        inv;
  logic signed [10:0] y_s, tgt, diff, mag, delta, sum;

  always_comb begin
    zone          = classify_zone(joy, DOWN_FAST, DOWN_SLOW, UP_SLOW, UP_FAST);
    fast          = (zone == ZONE_DOWN_FAST) || (zone == ZONE_UP_FAST);
    inv           = 10'd1023 - joy;
    y_s           = signed'({1'b0, y_cur});
    tgt           = '0;
    diff          = '0;
    mag           = '0;
    delta         = '0;
    hold_cnt_next = '0;
    zone_next     = ZONE_HOLD;

    if (!valid) begin
      delta = '0;
    end else if (pos_mode) begin
      tgt = signed'(11'(inv >> 1));
      if (tgt < Y_LO) tgt = Y_LO;
      if (tgt > Y_HI) tgt = Y_HI;
      diff = tgt - y_s;
      if (diff > BOOST_S)       delta = BOOST_S;
      else if (diff < -BOOST_S) delta = -BOOST_S;
      else                      delta = diff;
    end else begin
      zone_next = zone;
      // Acceleration only builds over consecutive fast updates in one direction.
      if (fast && (prev_zone == zone))
        hold_cnt_next = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
      if (fast)
        mag = (hold_cnt_next == CNT_MAX) ? BOOST_S : FAST_S;
      else if (zone != ZONE_HOLD)
        mag = SLOW_S;
      delta = ((zone == ZONE_DOWN_FAST) || (zone == ZONE_DOWN_SLOW)) ? -mag : mag;
    end

    sum = y_s + delta;
    if (sum < Y_LO) sum = Y_LO;
    if (sum > Y_HI) sum = Y_HI;
    y_next = 10'(sum);
  end

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Frame-synchronised paddle position controller: each VGA end-of-frame starts
// a sweep that updates one channel per clock through a shared step calculator.
module paddle_motion_ctrl
  import paddle_pkg::*;
#(
  parameter int         NUM_CH       = DEF_NUM_CH,
  parameter int         Y_MIN        = DEF_Y_MIN,
  parameter int         Y_MAX        = DEF_Y_MAX,
  parameter int         PADDLE_H     = DEF_PADDLE_H,
  parameter int         Y_RESET      = DEF_Y_RESET,
  parameter logic [9:0] DOWN_FAST    = DEF_DOWN_FAST,
  parameter logic [9:0] DOWN_SLOW    = DEF_DOWN_SLOW,
  parameter logic [9:0] UP_SLOW      = DEF_UP_SLOW,
  parameter logic [9:0] UP_FAST      = DEF_UP_FAST,
  parameter int         SLOW_STEP    = DEF_SLOW_STEP,
  parameter int         FAST_STEP    = DEF_FAST_STEP,
  parameter int         BOOST_STEP   = DEF_BOOST_STEP,
  parameter int         ACCEL_FRAMES = DEF_ACCEL_FRAMES
) (
  input  logic                  clk50M,
  input  logic                  reset,
  input  logic                  endofframe,
  input  logic [10*NUM_CH-1:0]  joy_y,
  input  logic [NUM_CH-1:0]     joy_valid,
  input  logic [NUM_CH-1:0]     mode,
  output logic [10*NUM_CH-1:0]  y,
  output logic                  busy,
  output logic                  update_done,
  output logic                  overrun
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  logic              sync1_reg, sync2_reg, sync3_reg;
  logic              frame_evt;
  seq_state_t        state_reg;
  logic [CH_W-1:0]   ch_reg;
  logic [9:0]        y_reg    [NUM_CH];
  logic [CNT_W-1:0]  cnt_reg  [NUM_CH];
  zone_t             zone_reg [NUM_CH];
  logic              busy_reg, done_reg, overrun_reg;

  logic [9:0]        cur_joy;
  logic [9:0]        y_next;
  logic [CNT_W-1:0]  cnt_next;
  zone_t             zone_next;

  assign frame_evt = sync2_reg & ~sync3_reg;

  always_comb begin
    cur_joy = joy_y[10*int'(ch_reg) +: 10];
  end

  paddle_step_calc #(
    .Y_MIN        (Y_MIN),
    .Y_LIM        (Y_MAX - PADDLE_H),
    .DOWN_FAST    (DOWN_FAST),
    .DOWN_SLOW    (DOWN_SLOW),
    .UP_SLOW      (UP_SLOW),
    .UP_FAST      (UP_FAST),
    .SLOW_STEP    (SLOW_STEP),
    .FAST_STEP    (FAST_STEP),
    .BOOST_STEP   (BOOST_STEP),
    .ACCEL_FRAMES (ACCEL_FRAMES),
    .CNT_W        (CNT_W)
  ) u_step (
    .y_cur         (y_reg[ch_reg]),
    .joy           (cur_joy),
    .valid         (joy_valid[ch_reg]),
    .pos_mode      (mode[ch_reg]),
    .hold_cnt      (cnt_reg[ch_reg]),
    .prev_zone     (zone_reg[ch_reg]),
    .y_next        (y_next),
    .hold_cnt_next (cnt_next),
    .zone_next     (zone_next)
  );

  always_ff @(posedge clk50M) begin
    if (reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      sync3_reg   <= 1'b0;
      state_reg   <= ST_IDLE;
      ch_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        y_reg[i]    <= 10'(Y_RESET);
        cnt_reg[i]  <= '0;
        zone_reg[i] <= ZONE_HOLD;
      end
    end else begin
      sync1_reg   <= endofframe;
      sync2_reg   <= sync1_reg;
      sync3_reg   <= sync2_reg;
      done_reg    <= 1'b0;
      // An edge arriving mid-sweep is discarded; only the pulse records it.
      overrun_reg <= frame_evt && (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (frame_evt) begin
            state_reg <= ST_SWEEP;
            ch_reg    <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          y_reg[ch_reg]    <= y_next;
          cnt_reg[ch_reg]  <= cnt_next;
          zone_reg[ch_reg] <= zone_next;
          if (ch_reg == CH_LAST) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            ch_reg <= ch_reg + CH_W'(1);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          ch_reg    <= '0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_y_out
      assign y[10*gi +: 10] = y_reg[gi];
    end
  endgenerate

  assign busy        = busy_reg;
  assign update_done = done_reg;
  assign overrun     = overrun_reg;

endmodule
